// File: rtl/axis_input_dma_sequencer.sv
// Layer scheduler for the input stage: issues one pixel/weight MM2S command
// pair per weight iteration and tracks tlast completion of both streams.
module axis_input_dma_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int BTT_WIDTH  = 23,
    parameter int ITR_WIDTH  = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ITR_WIDTH-1:0]  cfg_itrs,
    input  logic [ADDR_WIDTH-1:0] cfg_px_addr,
    input  logic [BTT_WIDTH-1:0]  cfg_px_bytes,
    input  logic [ADDR_WIDTH-1:0] cfg_w_addr,
    input  logic [BTT_WIDTH-1:0]  cfg_w_bytes,
    output logic                  m_px_cmd_valid,
    input  logic                  m_px_cmd_ready,
    output logic [ADDR_WIDTH-1:0] m_px_cmd_addr,
    output logic [BTT_WIDTH-1:0]  m_px_cmd_bytes,
    output logic                  m_w_cmd_valid,
    input  logic                  m_w_cmd_ready,
    output logic [ADDR_WIDTH-1:0] m_w_cmd_addr,
    output logic [BTT_WIDTH-1:0]  m_w_cmd_bytes,
    input  logic                  px_last_hs,
    input  logic                  w_last_hs,
    output logic                  busy,
    output logic [ITR_WIDTH-1:0]  itr_count,
    output logic                  done,
    output logic                  err_stray_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ITR_WIDTH-1:0]  itrs_r;
    logic [ADDR_WIDTH-1:0] px_addr_r;
    logic [BTT_WIDTH-1:0]  px_bytes_r;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [BTT_WIDTH-1:0]  w_bytes_r;
    logic                  px_valid_r;
    logic                  w_valid_r;
    logic                  px_done;
    logic                  w_done;
    logic                  done_r;
    logic                  err_r;

    logic px_hs;
    logic w_hs;
    logic last_itr;
    logic enter_issue;
    logic next_itr;
    logic stray;

    assign px_hs = px_valid_r & m_px_cmd_ready;
    assign w_hs  = w_valid_r & m_w_cmd_ready;

    // Full-width compare so cfg_itrs = 2^ITR_WIDTH-1 terminates correctly
    assign last_itr = (itr_count == (itrs_r - ITR_WIDTH'(1)));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_itrs == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if ((!px_valid_r || m_px_cmd_ready) &&
                    (!w_valid_r || m_w_cmd_ready)) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (px_done && w_done) begin
                    state_nx = last_itr ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign enter_issue = (state_nx == S_ISSUE) && (state != S_ISSUE);
    assign next_itr    = (state == S_WAIT) && (state_nx == S_ISSUE);

    always_comb begin
        stray = 1'b0;
        if ((state == S_IDLE) || (state == S_DONE)) begin
            stray = px_last_hs | w_last_hs;
        end else if (state == S_WAIT) begin
            stray = (px_last_hs & px_done) | (w_last_hs & w_done);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            itrs_r     <= '0;
            px_addr_r  <= '0;
            px_bytes_r <= '0;
            w_addr_r   <= '0;
            w_bytes_r  <= '0;
            itr_count  <= '0;
            px_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            px_done    <= 1'b0;
            w_done     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= (state == S_DONE);

            if ((state == S_IDLE) && cfg_valid) begin
                itrs_r     <= cfg_itrs;
                px_addr_r  <= cfg_px_addr;
                px_bytes_r <= cfg_px_bytes;
                w_addr_r   <= cfg_w_addr;
                w_bytes_r  <= cfg_w_bytes;
                itr_count  <= '0;
            end

            // Pixel image is re-read in place; only weights walk forward
            if (next_itr) begin
                itr_count <= itr_count + ITR_WIDTH'(1);
                w_addr_r  <= w_addr_r + ADDR_WIDTH'(w_bytes_r);
            end

            if (enter_issue) begin
                px_valid_r <= 1'b1;
                w_valid_r  <= 1'b1;
            end else begin
                if (px_hs) begin
                    px_valid_r <= 1'b0;
                end
                if (w_hs) begin
                    w_valid_r <= 1'b0;
                end
            end

            if (enter_issue) begin
                px_done <= 1'b0;
                w_done  <= 1'b0;
            end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
                if (px_last_hs) begin
                    px_done <= 1'b1;
                end
                if (w_last_hs) begin
                    w_done <= 1'b1;
                end
            end

            if (stray) begin
                err_r <= 1'b1;
            end
        end
    end

    assign cfg_ready      = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign done           = done_r;
    assign err_stray_last = err_r;
    assign m_px_cmd_valid = px_valid_r;
    assign m_px_cmd_addr  = px_addr_r;
    assign m_px_cmd_bytes = px_bytes_r;
    assign m_w_cmd_valid  = w_valid_r;
    assign m_w_cmd_addr   = w_addr_r;
    assign m_w_cmd_bytes  = w_bytes_r;

endmodule

// File: doc/axis_input_dma_sequencer.md
Name: axis_input_dma_sequencer

Overview:
- Layer-level scheduler for the input stage. It issues paired read commands to the pixel MM2S DMA and the weights MM2S DMA, one pair per weight iteration.
- It monitors the tlast handshakes on the pixel and weight AXIS inputs of the input pipe to detect when each iteration's transfers have completed.
- The pixel image is re-streamed from the same address every iteration. The weight address advances by one weight chunk per iteration.
- It sits between the host/config register block and the two DMA command ports. It reports layer completion with a done pulse.

Parameters:
ADDR_WIDTH, 32, byte-address width of DMA commands
BTT_WIDTH, 23, bytes-to-transfer field width
ITR_WIDTH, 10, width of iteration count

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
cfg_valid  in  1  layer config valid
cfg_ready  out  1  high only in IDLE
cfg_itrs  in  ITR_WIDTH  number of weight iterations for the layer
cfg_px_addr  in  ADDR_WIDTH  pixel base address
cfg_px_bytes  in  BTT_WIDTH  pixel bytes per iteration
cfg_w_addr  in  ADDR_WIDTH  weight base address
cfg_w_bytes  in  BTT_WIDTH  weight bytes per iteration (also the address stride)
m_px_cmd_valid  out  1  pixel DMA command valid
m_px_cmd_ready  in  1  pixel DMA command ready
m_px_cmd_addr  out  ADDR_WIDTH  pixel command address
m_px_cmd_bytes  out  BTT_WIDTH  pixel command length
m_w_cmd_valid  out  1  weight DMA command valid
m_w_cmd_ready  in  1  weight DMA command ready
m_w_cmd_addr  out  ADDR_WIDTH  weight command address
m_w_cmd_bytes  out  BTT_WIDTH  weight command length
px_last_hs  in  1  s_axis_pixels tvalid&tready&tlast
w_last_hs  in  1  s_axis_weights tvalid&tready&tlast
busy  out  1  state != IDLE
itr_count  out  ITR_WIDTH  current iteration index
done  out  1  one-cycle pulse at layer end
err_stray_last  out  1  sticky: a last pulse arrived in IDLE/DONE

Behaviour:
- Reset (aresetn low at the rising edge):
  - state = IDLE.
  - All outputs = 0, except cfg_ready = 1.
  - Counters, registered config, completion flags and err_stray_last are cleared.
  - Reset mid-operation abandons any outstanding commands immediately. The DMAs are reset by the same aresetn.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid, register all cfg_* fields and set itr_count = 0.
  - If cfg_itrs == 0: go to DONE. No commands are issued.
  - Otherwise: go to ISSUE, with px addr = cfg_px_addr and w addr = cfg_w_addr.
- ISSUE:
  - Entry clears px_done and w_done.
  - m_px_cmd_valid and m_w_cmd_valid both rise in the first ISSUE cycle. There is no combinational path from ready to valid.
  - Each valid drops in the cycle after its own valid&ready handshake. The two are independent and may be accepted in the same cycle or in either order.
  - addr and bytes are held stable while valid is high.
  - When both commands have been accepted, go to WAIT.
- Completion flags:
  - px_last_hs sets px_done, and w_last_hs sets w_done, in both ISSUE and WAIT. An early last before the other command is accepted is captured.
  - Simultaneous px and w last pulses set both flags in that cycle.
- WAIT:
  - When px_done and w_done are both set (the state registers the set flags; a last pulse arriving this cycle counts from the next cycle), do the following:
    - If itr_count == itrs-1, go to DONE.
    - Otherwise, increment itr_count, set w addr = w addr + w_bytes (mod 2^ADDR_WIDTH, wrap silently), keep px addr unchanged, and go to ISSUE.
- DONE:
  - done = 1 for exactly one cycle. Return to IDLE.
  - itr_count holds its final value until the next cfg accept.
- Stray last:
  - px_last_hs or w_last_hs while in IDLE or DONE sets err_stray_last.
  - A second last of the same stream in WAIT, after its flag is already set, also sets err_stray_last.
  - err_stray_last clears only on reset.
- Latency:
  - cfg accept to first command valid: 1 cycle.
  - Both flags set to the next command valid: 2 cycles.
  - Last completion to done: 1 cycle after the WAIT decision.
- Width rule: itr_count compares against the registered cfg_itrs-1 at full ITR_WIDTH. cfg_itrs = 2^ITR_WIDTH-1 is supported.

Test Plan:
- cfg_itrs=3, px_addr=0x1000, px_bytes=0x200, w_addr=0x8000, w_bytes=0x40, always-ready DMAs, px_last and w_last 10 cycles after each command -> 3 command pairs. w addrs 0x8000, 0x8040, 0x8080. px addr 0x1000 ×3. done once. itr_count ends at 2.
- cfg_itrs=2, m_w_cmd_ready delayed 5 cycles, px_last arrives before the w command is accepted -> px_done captured. The iteration completes only after w_last. m_w_cmd_addr is stable while stalled.
- px_last_hs and w_last_hs in the same cycle -> next ISSUE 2 cycles later. No lost completion.
- cfg_itrs=0 -> no command valids, done pulse 2 cycles after cfg accept, cfg_ready back high.
- w_addr=0xFFFFFFC0, w_bytes=0x40, cfg_itrs=2 -> second w addr = 0x00000000.
- aresetn low during WAIT of iteration 1 -> next cycle IDLE, valids 0, done not pulsed. A px_last_hs in IDLE afterwards sets err_stray_last=1.
